// File: rtl/nodes_cache_nway_if.sv
// Node record type and the request/response bundle shared by the expansion
// units and the N-way node cache.
package nodes_cache_pkg;
  typedef struct packed {
    logic [9:0]  parent;
    logic [15:0] g_cost;
    logic [15:0] f_cost;
    logic        open;
    logic        closed;
  } node_mem_t;
endpackage

interface nodes_cache_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PORTS  = 8
);
  logic [NUM_PORTS-1:0]                 valid;
  logic [NUM_PORTS-1:0]                 write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] address;
  nodes_cache_pkg::node_mem_t [NUM_PORTS-1:0] data_in;
  logic                                 ready;
  logic                                 flush;
  logic                                 busy;
  logic [NUM_PORTS-1:0]                 out_valid;
  logic [NUM_PORTS-1:0]                 hit;
  logic [NUM_PORTS-1:0]                 retry;
  nodes_cache_pkg::node_mem_t [NUM_PORTS-1:0] data_out;
  logic [31:0]                          hit_count;
  logic [31:0]                          miss_count;

  modport master (
    output valid, write, address, data_in, flush,
    input  ready, busy, out_valid, hit, retry, data_out, hit_count, miss_count
  );
  modport slave (
    input  valid, write, address, data_in, flush,
    output ready, busy, out_valid, hit, retry, data_out, hit_count, miss_count
  );
endinterface

// File: rtl/nodes_cache_nway.sv
// N-way set-associative multi-port A* node cache with true-LRU replacement,
// per-set write arbitration and a set-by-set flush. Optional hit/miss
// counters are built when NODES_CACHE_STATS_EN is defined.
module nodes_cache_nway
  import nodes_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int INDEX_SIZE = 5,
  parameter int TAG_WIDTH  = ADDR_WIDTH - INDEX_SIZE,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_PORTS  = 8
) (
  input logic          clk,
  input logic          rst,
  nodes_cache_if.slave bus
);
  localparam int NUM_SETS = 1 << INDEX_SIZE;
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  typedef logic [WAY_BITS-1:0]   way_t;
  typedef logic [INDEX_SIZE-1:0] idx_t;
  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef enum logic {IDLE, FLUSH} state_t;

  logic [NUM_WAYS-1:0] line_vld_q [NUM_SETS];
  way_t                age_q      [NUM_SETS][NUM_WAYS];
  tag_t                tag_q      [NUM_SETS][NUM_WAYS];
  node_mem_t           data_q     [NUM_SETS][NUM_WAYS];

  state_t state_q, state_d;
  idx_t   cnt_q, cnt_d;
  logic   ready;

  idx_t                 idx       [NUM_PORTS];
  tag_t                 tag       [NUM_PORTS];
  way_t                 hit_way   [NUM_PORTS];
  way_t                 vic_way   [NUM_PORTS];
  way_t                 touch_way [NUM_PORTS];
  node_mem_t            rd_data   [NUM_PORTS];
  logic [NUM_PORTS-1:0] acc, is_hit, win, touch, alloc, upd_data;

  logic [NUM_PORTS-1:0]            vld_p1, hit_p1, retry_p1;
  node_mem_t [NUM_PORTS-1:0]       data_p1;

  assign ready = (state_q == IDLE);

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      idx[p] = bus.address[p][INDEX_SIZE-1:0];
      tag[p] = bus.address[p][ADDR_WIDTH-1:INDEX_SIZE];
      acc[p] = bus.valid[p] & ready;
    end
  end

  // Lookup against the state at the start of the cycle; victim prefers the
  // lowest invalid way, otherwise the oldest way.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      is_hit[p]  = 1'b0;
      hit_way[p] = '0;
      vic_way[p] = '0;
      rd_data[p] = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (line_vld_q[idx[p]][w] && (tag_q[idx[p]][w] == tag[p])) begin
          is_hit[p]  = 1'b1;
          hit_way[p] = way_t'(w);
          rd_data[p] = data_q[idx[p]][w];
        end
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[idx[p]][w] == way_t'(NUM_WAYS - 1)) vic_way[p] = way_t'(w);
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (!line_vld_q[idx[p]][w]) vic_way[p] = way_t'(w);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      win[p] = acc[p];
      for (int q = 0; q < p; q++) begin
        if (acc[q] && (idx[q] == idx[p])) win[p] = 1'b0;
      end
      touch[p]     = win[p] & (is_hit[p] | bus.write[p]);
      alloc[p]     = win[p] & bus.write[p] & ~is_hit[p];
      upd_data[p]  = win[p] & bus.write[p];
      touch_way[p] = is_hit[p] ? hit_way[p] : vic_way[p];
    end
  end

  // Line state: valid bits and ages; only set winners touch a set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        line_vld_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= way_t'(w);
      end
    end else if (state_q == FLUSH) begin
      line_vld_q[cnt_q] <= '0;
      for (int w = 0; w < NUM_WAYS; w++) age_q[cnt_q][w] <= way_t'(w);
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (alloc[p]) line_vld_q[idx[p]][touch_way[p]] <= 1'b1;
        if (touch[p]) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_t'(w) == touch_way[p])
              age_q[idx[p]][w] <= '0;
            else if (age_q[idx[p]][w] < age_q[idx[p]][touch_way[p]])
              age_q[idx[p]][w] <= age_q[idx[p]][w] + way_t'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (upd_data[p]) begin
        data_q[idx[p]][touch_way[p]] <= bus.data_in[p];
        if (alloc[p]) tag_q[idx[p]][touch_way[p]] <= tag[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + idx_t'(1);
        if (cnt_q == idx_t'(NUM_SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= '0;
      hit_p1   <= '0;
      retry_p1 <= '0;
      data_p1  <= '0;
    end else begin
      vld_p1   <= acc;
      hit_p1   <= acc & is_hit;
      retry_p1 <= acc & bus.write & ~win;
      for (int p = 0; p < NUM_PORTS; p++)
        data_p1[p] <= (acc[p] && is_hit[p]) ? rd_data[p] : '0;
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = (state_q == FLUSH);
  assign bus.out_valid = vld_p1;
  assign bus.hit       = hit_p1;
  assign bus.retry     = retry_p1;
  assign bus.data_out  = data_p1;

`ifdef NODES_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  function automatic logic [31:0] pop(input logic [NUM_PORTS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Counts become visible together with the responses they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= sat_add(hit_cnt_q, pop(acc & is_hit));
      miss_cnt_q <= sat_add(miss_cnt_q, pop(acc & ~is_hit));
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_nodes_cache_nway.sv
// Bench for nodes_cache_nway: table vectors, directed corner sequences and
// randomized traffic against a recency-list model of the cache.
module tb_nodes_cache_nway;
  import nodes_cache_pkg::*;

  localparam int AW = 10;
  localparam int IS = 5;
  localparam int NW = 4;
  localparam int NP = 8;
  localparam int NS = 1 << IS;
  localparam bit STATS =
`ifdef NODES_CACHE_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nodes_cache_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus ();
  nodes_cache_nway #(.ADDR_WIDTH(AW), .INDEX_SIZE(IS), .NUM_WAYS(NW), .NUM_PORTS(NP))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: per set, tags in most-recently-used-first order; data keyed by address.
  int unsigned  lru [NS][$];
  node_mem_t    mem [int unsigned];
  int           fl;
  longint       exp_hc, exp_mc;
  logic [NP-1:0] e_vld, e_hit, e_retry;
  node_mem_t    e_data [NP];

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    int          dk;
    bit          ehit;
    int          edk;
  } vec_t;
  vec_t vecs [13];

  function automatic node_mem_t mkd(input int k);
    node_mem_t d;
    d.parent = 10'(k);
    d.g_cost = 16'(k * 3 + 1);
    d.f_cost = 16'hA000 | 16'(k);
    d.open   = 1'b1;
    d.closed = k[0];
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int find(input int s, input int unsigned t);
    for (int i = 0; i < lru[s].size(); i++) if (lru[s][i] == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) lru[s].delete();
    mem.delete();
    fl = 0; exp_hc = 0; exp_mc = 0;
    e_vld = '0; e_hit = '0; e_retry = '0;
    for (int p = 0; p < NP; p++) e_data[p] = '0;
  endtask

  task automatic model_step();
    bit used [NS];
    bit rdy;
    int s, i;
    int unsigned t, a, victim;
    rdy = (fl == 0);
    for (int k = 0; k < NS; k++) used[k] = 1'b0;
    e_vld = '0; e_hit = '0; e_retry = '0;
    for (int p = 0; p < NP; p++) begin
      e_data[p] = '0;
      if (bus.valid[p] && rdy) begin
        a = int'(bus.address[p]); s = a % NS; t = a / NS;
        e_vld[p] = 1'b1;
        e_hit[p] = (find(s, t) >= 0);
        if (e_hit[p]) begin e_data[p] = mem[a]; exp_hc++; end
        else exp_mc++;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (!e_vld[p]) continue;
      a = int'(bus.address[p]); s = a % NS; t = a / NS;
      if (used[s]) begin
        if (bus.write[p]) e_retry[p] = 1'b1;
        continue;
      end
      used[s] = 1'b1;
      if (e_hit[p]) begin
        i = find(s, t);
        lru[s].delete(i);
        lru[s].push_front(t);
        if (bus.write[p]) mem[a] = bus.data_in[p];
      end else if (bus.write[p]) begin
        if (lru[s].size() == NW) begin
          victim = lru[s].pop_back();
          mem.delete(victim * NS + s);
        end
        lru[s].push_front(t);
        mem[a] = bus.data_in[p];
      end
    end
    if (fl > 0) fl--;
    else if (bus.flush) begin
      fl = NS;
      for (int k = 0; k < NS; k++) lru[k].delete();
      mem.delete();
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(e_vld));
    chk("hit", 64'(bus.hit), 64'(e_hit));
    chk("retry", 64'(bus.retry), 64'(e_retry));
    for (int p = 0; p < NP; p++)
      chk($sformatf("data_out[%0d]", p), 64'(bus.data_out[p]), 64'(e_data[p]));
    chk("busy", 64'(bus.busy), 64'(fl > 0));
    chk("ready", 64'(bus.ready), 64'(fl == 0));
    chk("hit_count", 64'(bus.hit_count), STATS ? 64'(exp_hc) : 64'd0);
    chk("miss_count", 64'(bus.miss_count), STATS ? 64'(exp_mc) : 64'd0);
  endtask

  task automatic idle_in();
    bus.valid = '0; bus.write = '0; bus.flush = 1'b0;
    for (int p = 0; p < NP; p++) begin bus.address[p] = '0; bus.data_in[p] = '0; end
  endtask

  task automatic one(input int port, input bit wr, input logic [9:0] addr, input node_mem_t d);
    idle_in();
    bus.valid[port] = 1'b1; bus.write[port] = wr;
    bus.address[port] = addr; bus.data_in[port] = d;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_hit_retry"}, 64'({bus.hit, bus.retry}), 64'd0);
    chk({tag, "_data0"}, 64'(bus.data_out[0]), 64'd0);
    chk({tag, "_counts"}, {bus.hit_count, bus.miss_count}, 64'd0);
  endtask

  initial begin
    int n, guard;
    vecs[0]  = '{0, 10'h025, 0, 0, 0};
    vecs[1]  = '{1, 10'h025, 1, 0, 0};
    vecs[2]  = '{0, 10'h025, 0, 1, 1};
    vecs[3]  = '{1, 10'h045, 2, 0, 0};
    vecs[4]  = '{1, 10'h065, 3, 0, 0};
    vecs[5]  = '{1, 10'h085, 4, 0, 0};
    vecs[6]  = '{0, 10'h025, 0, 1, 1};
    vecs[7]  = '{1, 10'h0A5, 5, 0, 0};
    vecs[8]  = '{0, 10'h045, 0, 0, 0};
    vecs[9]  = '{0, 10'h025, 0, 1, 1};
    vecs[10] = '{0, 10'h065, 0, 1, 3};
    vecs[11] = '{0, 10'h085, 0, 1, 4};
    vecs[12] = '{0, 10'h0A5, 0, 1, 5};

    idle_in();
    model_reset();
    #1;
    check_reset_state("reset");
    #12 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      one(0, vecs[i].wr, vecs[i].addr, mkd(vecs[i].dk));
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid[0]), 64'd1);
      chk($sformatf("vec%0d_hit", i), 64'(bus.hit[0]), 64'(vecs[i].ehit));
      chk($sformatf("vec%0d_data", i), 64'(bus.data_out[0]),
          vecs[i].ehit ? 64'(mkd(vecs[i].edk)) : 64'd0);
    end

    // Set 3 conflict: two writers and a reader in the same cycle.
    one(0, 1'b1, 10'h0E3, mkd(7)); tick();
    idle_in();
    bus.valid[2] = 1; bus.write[2] = 1; bus.address[2] = 10'h103; bus.data_in[2] = mkd(8);
    bus.valid[6] = 1; bus.write[6] = 1; bus.address[6] = 10'h123; bus.data_in[6] = mkd(9);
    bus.valid[4] = 1; bus.write[4] = 0; bus.address[4] = 10'h0E3;
    tick();
    chk("conf_retry2", 64'(bus.retry[2]), 64'd0);
    chk("conf_retry6", 64'(bus.retry[6]), 64'd1);
    chk("conf_hit4", 64'(bus.hit[4]), 64'd1);
    chk("conf_data4", 64'(bus.data_out[4]), 64'(mkd(7)));
    one(0, 1'b0, 10'h123, '0); tick();
    chk("conf_loser_absent", 64'(bus.hit[0]), 64'd0);
    one(0, 1'b0, 10'h103, '0); tick();
    chk("conf_winner_hit", 64'(bus.hit[0]), 64'd1);
    chk("conf_winner_data", 64'(bus.data_out[0]), 64'(mkd(8)));

    // Flush: busy for exactly NS cycles, requests ignored meanwhile.
    idle_in(); bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    n = 0; guard = 0;
    while (bus.busy && guard < 40) begin
      n++; guard++;
      bus.valid = '1; bus.address[1] = 10'h025; bus.flush = 1'b1;
      tick();
      chk("flush_no_resp", 64'(bus.out_valid), 64'd0);
    end
    chk("flush_busy_cycles", 64'(n), 64'(NS));
    idle_in();
    one(0, 1'b0, 10'h025, '0); tick(); chk("post_flush_025", 64'(bus.hit[0]), 64'd0);
    one(0, 1'b0, 10'h0A5, '0); tick(); chk("post_flush_0A5", 64'(bus.hit[0]), 64'd0);
    one(0, 1'b0, 10'h103, '0); tick(); chk("post_flush_103", 64'(bus.hit[0]), 64'd0);

    // Randomized traffic on a few sets to force conflicts and evictions.
    for (int c = 0; c < 500; c++) begin
      idle_in();
      bus.valid = NP'($urandom);
      bus.write = NP'($urandom);
      bus.flush = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < NP; p++) begin
        bus.address[p] = AW'($urandom_range(0, 7) * NS + $urandom_range(0, 3));
        bus.data_in[p] = node_mem_t'({$urandom, $urandom});
      end
      tick();
    end
    idle_in();
    guard = 0;
    while (bus.busy && guard < 40) begin guard++; tick(); end
    chk("drain_busy", 64'(bus.busy), 64'd0);

    // Reset during a flush returns to the reset state at once.
    idle_in(); bus.flush = 1'b1; tick();
    idle_in(); tick(); tick();
    rst = 1'b1; model_reset();
    #1;
    check_reset_state("midflush_reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Statistics: 3 hits, 2 misses; flush keeps them; reset clears them.
    one(0, 1'b1, 10'h011, mkd(11)); tick();
    for (int i = 0; i < 3; i++) begin one(0, 1'b0, 10'h011, '0); tick(); end
    one(0, 1'b0, 10'h031, '0); tick();
    chk("stats_hits", 64'(bus.hit_count), STATS ? 64'd3 : 64'd0);
    chk("stats_misses", 64'(bus.miss_count), STATS ? 64'd2 : 64'd0);
    idle_in(); bus.flush = 1'b1; tick();
    idle_in();
    guard = 0;
    while (bus.busy && guard < 40) begin guard++; tick(); end
    chk("stats_hits_after_flush", 64'(bus.hit_count), STATS ? 64'd3 : 64'd0);
    chk("stats_misses_after_flush", 64'(bus.miss_count), STATS ? 64'd2 : 64'd0);
    rst = 1'b1; model_reset();
    #1;
    check_reset_state("final_reset");
    #1 rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
